periph_timer: RTL and testbench

- Memory-mapped machine timer peripheral; attaches to one "Any" peripheral port (p2/p3/p4) of the crossbar and consumes its req/addr/wen/wdata/be stream.
- Provides a 64-bit prescaled mtime counter, a 64-bit mtimecmp compare register and a level interrupt to the core.
- Each bus transaction is answered with a single-cycle ready pulse carrying read data.

---
 rtl/periph_timer.sv | 184 ++++++++++++++++++
 tb/tb_periph_timer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/periph_timer.sv
// periph_timer: memory-mapped machine timer behind a crossbar peripheral port.
// It has a prescaled 64-bit mtime, a 64-bit mtimecmp, a sticky PENDING flag and a level irq_o.
// Optional build macro PERIPH_TIMER_SNAPSHOT_EN: a read of MTIME_LO latches mtime[63:32]
// into a shadow register, and MTIME_HI then returns that shadow.
module periph_timer #(
  parameter int WORD_ADDR_WIDTH = 16,
  parameter int PRESCALE_WIDTH  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       p_req_i,
  input  logic [WORD_ADDR_WIDTH-3:0] p_addr_i,
  input  logic                       p_wen_i,
  input  logic [31:0]                p_wdata_i,
  input  logic [3:0]                 p_be_i,
  output logic [31:0]                p_rdata_o,
  output logic                       p_ready_o,
  output logic                       irq_o
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  state_e                      state_q;
  logic [31:0]                 rdata_q;
  logic                        ready_q;
  logic                        en_q, en_d, irq_en_q, irq_en_d;
  logic [PRESCALE_WIDTH-1:0]   prescale_q, prescale_d, pcnt_q, pcnt_d;
  logic [63:0]                 mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic                        pending_q, pending_d, irq_q, irq_d;
  logic                        accept, wr_en, rd_en, tick, cmp;
  logic [2:0]                  sel;
  logic [31:0]                 rd_val, ps32, ps_wr;
  logic                        unused_bits;
`ifdef PERIPH_TIMER_SNAPSHOT_EN
  logic [31:0]                 shadow_q, shadow_d;
`endif

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] wd,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  // Bus decode, compare and prescaler terminal count.
  always_comb begin
    accept = (state_q == IDLE) && p_req_i;
    wr_en  = accept && p_wen_i;
    rd_en  = accept && !p_wen_i;
    sel    = p_addr_i[2:0];
    cmp    = (mtime_q >= mtimecmp_q);
    tick   = en_q && (pcnt_q == prescale_q);
    ps32   = '0;
    ps32[PRESCALE_WIDTH-1:0] = prescale_q;
    ps_wr  = merge_be(ps32, p_wdata_i, p_be_i);
  end

  // Upper address bits alias by design and only part of the merged prescale word is kept.
  assign unused_bits = ^{p_addr_i, ps_wr};

  // Read mux; values are taken before any write at the same edge.
  always_comb begin
    rd_val = '0;
    case (sel)
      3'd0: rd_val = {30'd0, irq_en_q, en_q};
      3'd1: rd_val = ps32;
      3'd2: rd_val = mtime_q[31:0];
`ifdef PERIPH_TIMER_SNAPSHOT_EN
      3'd3: rd_val = shadow_q;
`else
      3'd3: rd_val = mtime_q[63:32];
`endif
      3'd4: rd_val = mtimecmp_q[31:0];
      3'd5: rd_val = mtimecmp_q[63:32];
      3'd6: rd_val = {31'd0, pending_q};
      default: rd_val = '0;
    endcase
  end

  // Register-file next state, the prescaler and mtime, and the PENDING/irq logic.
  always_comb begin
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;

    if (wr_en && sel == 3'd0 && p_be_i[0]) begin
      en_d     = p_wdata_i[0];
      irq_en_d = p_wdata_i[1];
    end
    if (wr_en && sel == 3'd1) prescale_d = ps_wr[PRESCALE_WIDTH-1:0];

    if (wr_en && (sel == 3'd0 || sel == 3'd1)) pcnt_d = '0;
    else if (tick)                              pcnt_d = '0;
    else if (en_q)                              pcnt_d = pcnt_q + PRESCALE_WIDTH'(1);

    // A write to either mtime half takes priority over the increment in that cycle.
    if (wr_en && sel == 3'd2)      mtime_d[31:0]  = merge_be(mtime_q[31:0], p_wdata_i, p_be_i);
    else if (wr_en && sel == 3'd3) mtime_d[63:32] = merge_be(mtime_q[63:32], p_wdata_i, p_be_i);
    else if (tick)                 mtime_d        = mtime_q + 64'd1;

    if (wr_en && sel == 3'd4) mtimecmp_d[31:0]  = merge_be(mtimecmp_q[31:0], p_wdata_i, p_be_i);
    if (wr_en && sel == 3'd5) mtimecmp_d[63:32] = merge_be(mtimecmp_q[63:32], p_wdata_i, p_be_i);

    // If a compare hit and a clear land in the same cycle, the hit wins.
    if (cmp)                                                  pending_d = 1'b1;
    else if (wr_en && sel == 3'd6 && p_be_i[0] && p_wdata_i[0]) pending_d = 1'b0;
    else                                                      pending_d = pending_q;

    irq_d = pending_q & irq_en_q;
  end

`ifdef PERIPH_TIMER_SNAPSHOT_EN
  // Latch the high half on a MTIME_LO read so a LO-then-HI pair is coherent.
  always_comb begin
    shadow_d = shadow_q;
    if (rd_en && sel == 3'd2) shadow_d = mtime_q[63:32];
  end

  // Shadow register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) shadow_q <= '0;
    else         shadow_q <= shadow_d;
  end
`endif

  // Bus FSM: accept in IDLE, answer with a one-cycle ready pulse in RESP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (p_req_i) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            rdata_q <= p_wen_i ? 32'd0 : rd_val;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          rdata_q <= '0;
        end
      endcase
    end
  end

  // Timer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      pending_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      pending_q  <= pending_d;
      irq_q      <= irq_d;
    end
  end

  assign p_ready_o = ready_q;
  assign p_rdata_o = rdata_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_periph_timer.sv
// Directed bench for periph_timer with hand-computed expectations.
module tb_periph_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [13:0] addr = '0;
  logic        wen = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        irq;

  int checks = 0;
  int errors = 0;

  periph_timer #(.WORD_ADDR_WIDTH(16), .PRESCALE_WIDTH(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .p_req_i(req), .p_addr_i(addr), .p_wen_i(wen),
    .p_wdata_i(wdata), .p_be_i(be), .p_rdata_o(rdata), .p_ready_o(ready), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    req = 1'b0; wen = 1'b0; addr = '0; wdata = '0; be = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One transaction: accept at the next rising edge; returns data/ready sampled after that edge
  // and the ready level one cycle later.
  task automatic bus(input logic w, input logic [13:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] rd, output logic rdy,
                     output logic rdy_next);
    @(negedge clk);
    req = 1'b1; wen = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    req = 1'b0; wen = 1'b0;
    rd = rdata; rdy = ready;
    @(posedge clk); #1;
    rdy_next = ready;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic r1, r2;
    do_reset();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b exp 0", ready); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b exp 0", irq); end
    bus(1'b0, 14'h1234, 32'd0, 4'h0, rd, r1, r2);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_lo got %h exp ffffffff", rd); end
    checks++; if (r1 !== 1'b1 || r2 !== 1'b0) begin errors++; $display("FAIL reset_cmp_lo_ready got %0b%0b exp 10", r1, r2); end
    bus(1'b0, 14'd5, 32'd0, 4'h0, rd, r1, r2);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_hi got %h exp ffffffff", rd); end
    checks++; if (r1 !== 1'b1 || r2 !== 1'b0) begin errors++; $display("FAIL reset_cmp_hi_ready got %0b%0b exp 10", r1, r2); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL idle_rdata got %h exp 0", rdata); end
  endtask

  task automatic test_prescale();
    logic [31:0] rd; logic r1, r2;
    do_reset();
    bus(1'b1, 14'd1, 32'd3, 4'hF, rd, r1, r2);
    bus(1'b1, 14'd0, 32'd1, 4'hF, rd, r1, r2);
    repeat (39) @(posedge clk);
    #1;
    bus(1'b0, 14'd2, 32'd0, 4'h0, rd, r1, r2);
    checks++; if (rd !== 32'd10) begin errors++; $display("FAIL prescale3 got %0d exp 10", rd); end
    do_reset();
    bus(1'b1, 14'd0, 32'd1, 4'hF, rd, r1, r2);
    bus(1'b0, 14'd2, 32'd0, 4'h0, rd, r1, r2);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL prescale0_a got %0d exp 1", rd); end
    bus(1'b0, 14'd2, 32'd0, 4'h0, rd, r1, r2);
    checks++; if (rd !== 32'd3) begin errors++; $display("FAIL prescale0_b got %0d exp 3", rd); end
  endtask

  task automatic test_carry();
    logic [31:0] rd; logic r1, r2;
    do_reset();
    bus(1'b1, 14'd2, 32'hFFFF_FFFE, 4'hF, rd, r1, r2);
    bus(1'b1, 14'd3, 32'd0, 4'hF, rd, r1, r2);
    bus(1'b1, 14'd0, 32'd1, 4'hF, rd, r1, r2);
    repeat (3) @(posedge clk);
    #1;
    bus(1'b0, 14'd2, 32'd0, 4'h0, rd, r1, r2);
    checks++; if (rd !== 32'd2) begin errors++; $display("FAIL carry_lo got %h exp 2", rd); end
    bus(1'b0, 14'd3, 32'd0, 4'h0, rd, r1, r2);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL carry_hi got %h exp 1", rd); end
  endtask

  task automatic test_collision();
    logic [31:0] rd; logic r1, r2;
    do_reset();
    bus(1'b1, 14'd0, 32'd1, 4'hF, rd, r1, r2);
    bus(1'b1, 14'd2, 32'h100, 4'hF, rd, r1, r2);
    bus(1'b0, 14'd2, 32'd0, 4'h0, rd, r1, r2);
    checks++; if (rd !== 32'h101) begin errors++; $display("FAIL collision got %h exp 101", rd); end
  endtask

  task automatic test_compare();
    logic [31:0] rd; logic r1, r2;
    do_reset();
    bus(1'b1, 14'd4, 32'h20, 4'hF, rd, r1, r2);
    bus(1'b1, 14'd5, 32'd0, 4'hF, rd, r1, r2);
    bus(1'b1, 14'd0, 32'd3, 4'hF, rd, r1, r2);
    repeat (32) @(posedge clk);
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %0b exp 0", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %0b exp 1", irq); end
    bus(1'b1, 14'd6, 32'd1, 4'h1, rd, r1, r2);
    bus(1'b0, 14'd6, 32'd0, 4'h0, rd, r1, r2);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL pending_set_wins got %0d exp 1", rd); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_held got %0b exp 1", irq); end
    bus(1'b1, 14'd5, 32'hFFFF_FFFF, 4'hF, rd, r1, r2);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_sticky got %0b exp 1", irq); end
    bus(1'b1, 14'd6, 32'd1, 4'h1, rd, r1, r2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got %0b exp 0", irq); end
    bus(1'b0, 14'd6, 32'd0, 4'h0, rd, r1, r2);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL pending_clear got %0d exp 0", rd); end
  endtask

  task automatic test_bytes();
    logic [31:0] rd; logic r1, r2;
    do_reset();
    bus(1'b1, 14'd4, 32'hAABB_CCDD, 4'b0010, rd, r1, r2);
    checks++; if (rd !== 32'd0 || r1 !== 1'b1) begin errors++; $display("FAIL write_resp got %h/%0b exp 0/1", rd, r1); end
    bus(1'b0, 14'd4, 32'd0, 4'h0, rd, r1, r2);
    checks++; if (rd !== 32'hFFFF_CCFF) begin errors++; $display("FAIL be_merge got %h exp ffffccff", rd); end
    bus(1'b1, 14'd7, 32'h1234_5678, 4'hF, rd, r1, r2);
    bus(1'b0, 14'd7, 32'd0, 4'h0, rd, r1, r2);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL unmapped got %h exp 0", rd); end
    bus(1'b1, 14'd1, 32'hFFFF_FFFF, 4'hF, rd, r1, r2);
    bus(1'b0, 14'd1, 32'd0, 4'h0, rd, r1, r2);
    checks++; if (rd !== 32'h0000_FFFF) begin errors++; $display("FAIL prescale_width got %h exp 0000ffff", rd); end
    bus(1'b1, 14'd0, 32'hFFFF_FFFF, 4'hF, rd, r1, r2);
    bus(1'b0, 14'd0, 32'd0, 4'h0, rd, r1, r2);
    checks++; if (rd !== 32'd3) begin errors++; $display("FAIL ctrl_bits got %h exp 3", rd); end
  endtask

  task automatic test_snapshot();
    logic [31:0] rd; logic r1, r2;
    logic [31:0] exp_hi;
`ifdef PERIPH_TIMER_SNAPSHOT_EN
    exp_hi = 32'd0;
`else
    exp_hi = 32'd1;
`endif
    do_reset();
    bus(1'b1, 14'd2, 32'hFFFF_FFFD, 4'hF, rd, r1, r2);
    bus(1'b1, 14'd0, 32'd1, 4'hF, rd, r1, r2);
    @(posedge clk); #1;
    bus(1'b0, 14'd2, 32'd0, 4'h0, rd, r1, r2);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL snap_lo got %h exp ffffffff", rd); end
    bus(1'b0, 14'd3, 32'd0, 4'h0, rd, r1, r2);
    checks++; if (rd !== exp_hi) begin errors++; $display("FAIL snap_hi got %h exp %h", rd, exp_hi); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_rdy;
    exp_rdy = 4'b0101;
    do_reset();
    @(negedge clk);
    req = 1'b1; wen = 1'b0; addr = 14'd4;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ready !== exp_rdy[i] || rdata !== (exp_rdy[i] ? 32'hFFFF_FFFF : 32'd0)) begin
        errors++; $display("FAIL b2b_%0d got %0b/%h exp %0b", i, ready, rdata, exp_rdy[i]);
      end
    end
    req = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    @(negedge clk);
    req = 1'b1; wen = 1'b0; addr = 14'd5;
    @(posedge clk); #1;
    req = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_pre got %0b exp 1", ready); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b0 || rdata !== 32'd0) begin errors++; $display("FAIL mid_reset got %0b/%h exp 0/0", ready, rdata); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_dropped got %0b exp 0", ready); end
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_carry();
    test_collision();
    test_compare();
    test_bytes();
    test_snapshot();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
